// File: rtl/mem_port_arbiter.sv
// Round-robin N-to-1 memory port arbiter, one outstanding transaction.
// Define MEM_ARB_PERF_CNT_EN to add saturating per-port grant counters.
package memory_pkg;
   localparam int MEM_ADDR_WIDTH = 32;
endpackage

module mem_port_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = memory_pkg::MEM_ADDR_WIDTH,
   parameter int DATA_W    = 32
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS-1:0]          we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
   input  logic [NUM_PORTS*DATA_W/8-1:0] be,
   output logic [NUM_PORTS-1:0]          gnt,
   output logic [NUM_PORTS-1:0]          rvalid,
   output logic [DATA_W-1:0]             rdata,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic [DATA_W/8-1:0]           mem_be,
   input  logic                          mem_rvalid,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic [NUM_PORTS*32-1:0]       perf_gnt_cnt
);
   localparam int BE_W  = DATA_W/8;
   localparam int IDX_W = $clog2(NUM_PORTS);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [IDX_W-1:0]     sel_q, sel_d;
   logic [NUM_PORTS-1:0] smp_q, smp_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [BE_W-1:0]      be_q, be_d;

   logic [NUM_PORTS-1:0] pend;
   logic                 found;
   logic [IDX_W-1:0]     pick;
   logic                 issue;
   logic                 rv_fire;
   int                   j;

   // Only requests seen across a full IDLE cycle are eligible.
   assign pend    = smp_q & req;
   assign issue   = (state_q == S_ISSUE);
   assign rv_fire = (state_q == S_WAIT) && mem_rvalid;

   always_comb begin
      found = 1'b0;
      pick  = last_q;
      j     = 0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         j = int'(last_q) + k;
         if (j >= NUM_PORTS) j = j - NUM_PORTS;
         if (!found && pend[IDX_W'(j)]) begin
            found = 1'b1;
            pick  = IDX_W'(j);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sel_d   = sel_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      smp_d   = (state_q == S_IDLE) ? req : '0;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_ISSUE;
               sel_d   = pick;
               for (int i = 0; i < NUM_PORTS; i++) begin
                  if (pick == IDX_W'(i)) begin
                     we_d    = we[i];
                     addr_d  = addr[i*ADDR_W +: ADDR_W];
                     wdata_d = wdata[i*DATA_W +: DATA_W];
                     be_d    = be[i*BE_W +: BE_W];
                  end
               end
            end
         end
         S_ISSUE: begin
            last_d  = sel_q;
            state_d = we_q ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         last_q  <= IDX_W'(NUM_PORTS-1);
         sel_q   <= '0;
         smp_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         smp_q   <= smp_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end

   always_comb begin
      gnt    = '0;
      rvalid = '0;
      if (issue)   gnt[sel_q]    = 1'b1;
      if (rv_fire) rvalid[sel_q] = 1'b1;
   end

   assign rdata     = rv_fire ? mem_rdata : '0;
   assign mem_req   = issue;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [NUM_PORTS-1:0][31:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (issue && (cnt_q[sel_q] != 32'hFFFF_FFFF)) begin
         cnt_q[sel_q] <= cnt_q[sel_q] + 32'd1;
      end
   end

   assign perf_gnt_cnt = cnt_q;
`else
   assign perf_gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester and memory models
// share one process; expectations queue at stimulus time.
module tb_mem_port_arbiter;
   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW/8;

   typedef struct {
      int              port;
      logic            w;
      logic [AW-1:0]   a;
      logic [DW-1:0]   d;
      logic [BW-1:0]   b;
   } txn_t;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic [NP-1:0]       req = '0;
   logic [NP-1:0]       we = '0;
   logic [NP*AW-1:0]    addr = '0;
   logic [NP*DW-1:0]    wdata = '0;
   logic [NP*BW-1:0]    be = '0;
   logic [NP-1:0]       gnt;
   logic [NP-1:0]       rvalid;
   logic [DW-1:0]       rdata;
   logic                mem_req;
   logic                mem_we;
   logic [AW-1:0]       mem_addr;
   logic [DW-1:0]       mem_wdata;
   logic [BW-1:0]       mem_be;
   logic                mem_rvalid = 1'b0;
   logic [DW-1:0]       mem_rdata = '0;
   logic [NP*32-1:0]    perf_gnt_cnt;

   always #5 clk = ~clk;

   mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .be(be), .gnt(gnt), .rvalid(rvalid),
      .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .perf_gnt_cnt(perf_gnt_cnt)
   );

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   txn_t          pq[NP][$];
   txn_t          gq[$];
   int            rqp[$];
   logic [DW-1:0] rqd[$];
   logic [NP-1:0] g_last = '0;
   int            ld_cyc[NP];
   int            gnt_cyc = 0;
   int            rv_cyc = 0;
   bit            mpend = 1'b0;
   int            mdue = 0;
   logic [AW-1:0] maddr = '0;
   int            exp_cnt[NP];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic txn_t mk(input int p, input logic w,
                               input logic [AW-1:0] a,
                               input logic [DW-1:0] d,
                               input logic [BW-1:0] b);
      txn_t t;
      t.port = p; t.w = w; t.a = a; t.d = d; t.b = b;
      return t;
   endfunction

   task automatic expect_gnt(input txn_t t, input bit rd_ok);
      gq.push_back(t);
      exp_cnt[t.port]++;
      if (!t.w && rd_ok) begin
         rqp.push_back(t.port);
         rqd.push_back(mem_f(t.a));
      end
   endtask

   task automatic cycle();
      txn_t          t;
      txn_t          e;
      logic [NP-1:0] oh;
      int            rp;
      logic [DW-1:0] rd;
      @(posedge clk);
      #1;
      cyc++;
      mem_rvalid = mpend && (cyc == mdue);
      mem_rdata  = mem_rvalid ? mem_f(maddr) : '0;
      if (mem_rvalid) mpend = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (req[p] && g_last[p]) req[p] = 1'b0;
         if (!req[p] && pq[p].size() > 0) begin
            t = pq[p].pop_front();
            req[p] = 1'b1;
            we[p] = t.w;
            addr[p*AW +: AW] = t.a;
            wdata[p*DW +: DW] = t.d;
            be[p*BW +: BW] = t.b;
            ld_cyc[p] = cyc;
         end
      end
      @(negedge clk);
      g_last = gnt;
      if (gnt != '0) begin
         gnt_cyc = cyc;
         if (gq.size() == 0) begin
            chk("gnt_unexpected", 64'(gnt), 64'(0));
         end else begin
            e = gq.pop_front();
            oh = '0;
            oh[e.port] = 1'b1;
            chk("gnt_port", 64'(gnt), 64'(oh));
            chk("mem_req", 64'(mem_req), 64'(1));
            chk("mem_we", 64'(mem_we), 64'(e.w));
            chk("mem_addr", 64'(mem_addr), 64'(e.a));
            if (e.w) begin
               chk("mem_wdata", 64'(mem_wdata), 64'(e.d));
               chk("mem_be", 64'(mem_be), 64'(e.b));
            end
         end
      end else if (mem_req) begin
         chk("mem_req_no_gnt", 64'(mem_req), 64'(0));
      end
      if (mem_req && !mem_we) begin
         mpend = 1'b1;
         mdue = cyc + 3;
         maddr = mem_addr;
      end
      if (rvalid != '0) begin
         rv_cyc = cyc;
         if (rqp.size() == 0) begin
            chk("rvalid_unexpected", 64'(rvalid), 64'(0));
         end else begin
            rp = rqp.pop_front();
            rd = rqd.pop_front();
            oh = '0;
            oh[rp] = 1'b1;
            chk("rvalid_port", 64'(rvalid), 64'(oh));
            chk("rdata", 64'(rdata), 64'(rd));
         end
      end else if (rdata != '0) begin
         chk("rdata_masked", 64'(rdata), 64'(0));
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req = '0;
      repeat (2) cycle();
      rstn = 1'b1;
      for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while ((gq.size() > 0 || rqp.size() > 0 || pq[0].size() > 0 ||
              pq[1].size() > 0 || req != '0) && n < maxc) begin
         cycle();
         n++;
      end
      if (n >= maxc) chk("drain_timeout", 64'(gq.size() + rqp.size()), 64'(0));
      repeat (3) cycle();
   endtask

   initial begin
      txn_t t;
      int   n;
      for (int p = 0; p < NP; p++) exp_cnt[p] = 0;

      rstn = 1'b0;
      repeat (3) cycle();
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_rvalid", 64'(rvalid), 64'(0));
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_rdata", 64'(rdata), 64'(0));
      chk("rst_perf", 64'(perf_gnt_cnt), 64'(0));
      rstn = 1'b1;

      // single read, latency 3 memory
      t = mk(0, 1'b0, 32'h100, '0, 4'hF);
      pq[0].push_back(t);
      expect_gnt(t, 1'b1);
      drain(40);
      chk("t1_gnt_lat", 64'(gnt_cyc - ld_cyc[0]), 64'(2));
      chk("t1_rv_lat", 64'(rv_cyc - ld_cyc[0]), 64'(5));

      // both ports streaming reads from reset
      do_reset();
      pq[0].push_back(mk(0, 1'b0, 32'h200, '0, 4'hF));
      pq[0].push_back(mk(0, 1'b0, 32'h208, '0, 4'hF));
      pq[1].push_back(mk(1, 1'b0, 32'h300, '0, 4'hF));
      pq[1].push_back(mk(1, 1'b0, 32'h308, '0, 4'hF));
      expect_gnt(mk(0, 1'b0, 32'h200, '0, 4'hF), 1'b1);
      expect_gnt(mk(1, 1'b0, 32'h300, '0, 4'hF), 1'b1);
      expect_gnt(mk(0, 1'b0, 32'h208, '0, 4'hF), 1'b1);
      expect_gnt(mk(1, 1'b0, 32'h308, '0, 4'hF), 1'b1);
      drain(100);

      // write on port 1, then a stray memory return
      t = mk(1, 1'b1, 32'h40, 32'h12345678, 4'hF);
      pq[1].push_back(t);
      expect_gnt(t, 1'b1);
      drain(40);
      mpend = 1'b1;
      mdue = cyc + 1;
      maddr = 32'h100;
      repeat (3) cycle();

      // reset while a read is outstanding
      t = mk(0, 1'b0, 32'h180, '0, 4'hF);
      pq[0].push_back(t);
      expect_gnt(t, 1'b0);
      n = 0;
      while (gnt == '0 && n < 20) begin
         cycle();
         n++;
      end
      chk("t4_gnt_seen", 64'(gq.size()), 64'(0));
      cycle();
      rstn = 1'b0;
      cycle();
      rstn = 1'b1;
      for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
      pq[1].push_back(mk(1, 1'b0, 32'h500, '0, 4'hF));
      pq[0].push_back(mk(0, 1'b0, 32'h600, '0, 4'hF));
      expect_gnt(mk(0, 1'b0, 32'h600, '0, 4'hF), 1'b1);
      expect_gnt(mk(1, 1'b0, 32'h500, '0, 4'hF), 1'b1);
      drain(80);

      // grant counters: 5 on port 0, 3 on port 1
      do_reset();
      for (int i = 0; i < 5; i++)
         pq[0].push_back(mk(0, 1'b1, 32'h1000 + 32'(i*4), 32'(i), 4'h3));
      for (int i = 0; i < 3; i++)
         pq[1].push_back(mk(1, 1'b1, 32'h2000 + 32'(i*4), 32'(i+8), 4'hC));
      for (int i = 0; i < 3; i++) begin
         expect_gnt(mk(0, 1'b1, 32'h1000 + 32'(i*4), 32'(i), 4'h3), 1'b1);
         expect_gnt(mk(1, 1'b1, 32'h2000 + 32'(i*4), 32'(i+8), 4'hC), 1'b1);
      end
      for (int i = 3; i < 5; i++)
         expect_gnt(mk(0, 1'b1, 32'h1000 + 32'(i*4), 32'(i), 4'h3), 1'b1);
      drain(100);
`ifdef MEM_ARB_PERF_CNT_EN
      chk("perf_cnt", 64'(perf_gnt_cnt),
          {32'(exp_cnt[1]), 32'(exp_cnt[0])});
`else
      chk("perf_cnt", 64'(perf_gnt_cnt), 64'(0));
`endif

      chk("left_gnt", 64'(gq.size()), 64'(0));
      chk("left_rd", 64'(rqp.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requester ports (port 0 = instruction fetch, port 1 = load/store); legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default memory_pkg::MEM_ADDR_WIDTH, byte address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; multiple of 8.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req  input  NUM_PORTS  per-port request, held until gnt.
REQ-007 SHALL have port we  input  NUM_PORTS  per-port write enable (1 = write, 0 = read).
REQ-008 SHALL have port addr  input  NUM_PORTS*ADDR_W  packed per-port address, port i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port wdata  input  NUM_PORTS*DATA_W  packed per-port write data.
REQ-010 SHALL have port be  input  NUM_PORTS*DATA_W/8  packed per-port byte enables.
REQ-011 SHALL have port gnt  output  NUM_PORTS  one-hot, one-cycle grant pulse.
REQ-012 SHALL have port rvalid  output  NUM_PORTS  one-hot, one-cycle read-data-valid pulse.
REQ-013 SHALL have port rdata  output  DATA_W  shared read data, valid where rvalid is set.
REQ-014 SHALL have ports mem_req/mem_we (output 1), mem_addr (output ADDR_W), mem_wdata (output DATA_W), mem_be (output DATA_W/8): single memory-side request.
REQ-015 SHALL have ports mem_rvalid (input 1), mem_rdata (input DATA_W): memory read return, arbitrary latency >= 1 cycle.
REQ-016 SHALL have port perf_gnt_cnt  output  NUM_PORTS*32  packed per-port grant counters.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-018 SHALL, in IDLE with any req bit set, select a port round-robin starting at (last_gnt+1) mod NUM_PORTS, register its index and fields, go to ISSUE.
REQ-019 SHALL, in ISSUE, drive mem_req=1 with registered we/addr/wdata/be and gnt[sel]=1 for exactly that cycle; grant latency = 2 cycles from req sampled in IDLE.
REQ-020 SHALL, from ISSUE, go to IDLE for a write and to WAIT for a read; update last_gnt to sel.
REQ-021 SHALL, in WAIT, pass mem_rdata to rdata and assert rvalid[sel] combinationally in the cycle mem_rvalid=1, then go to IDLE.
REQ-022 SHALL allow at most one outstanding transaction; req in ISSUE or WAIT is not sampled.
REQ-023 SHALL ignore mem_rvalid in IDLE or ISSUE (no rvalid output).
REQ-024 SHALL, with req deasserted while pending, still grant only ports whose req is set at IDLE sampling.
REQ-025 SHALL drive mem_req, gnt, rvalid to 0 in all cycles not listed above; mem_* data outputs hold last registered value.
REQ-026 SHALL ensure with all ports continuously requesting, each port is granted once per NUM_PORTS grants.

Reset
REQ-027 SHALL, when rstn=0 at a clock edge, go to IDLE, set last_gnt=NUM_PORTS-1 (port 0 wins first), clear registered fields, counters to 0.
REQ-028 SHALL, on reset during WAIT, abandon the read; no rvalid for it, any later mem_rvalid ignored per REQ-023.
REQ-029 SHALL hold outputs gnt=0, rvalid=0, mem_req=0, rdata=0-or-passthrough-masked-by-rvalid, perf_gnt_cnt=0 after reset.

Configuration
REQ-030 SHALL, with macro MEM_ARB_PERF_CNT_EN defined, increment perf_gnt_cnt slice i in each ISSUE cycle granting port i, saturating at 32'hFFFF_FFFF.
REQ-031 SHALL, without MEM_ARB_PERF_CNT_EN, tie perf_gnt_cnt to 0 and synthesize no counter flops; all other behaviour identical.

Verification
REQ-032 SHALL cover: NUM_PORTS=2, port 0 read addr 0x100 at cycle 0, memory returns 0xDEADBEEF after 3 cycles -> gnt[0] at cycle 2, rvalid[0]=1 with rdata 0xDEADBEEF at cycle 5.
REQ-033 SHALL cover: both ports requesting reads continuously from reset -> grant order 0,1,0,1; no port granted twice in a row.
REQ-034 SHALL cover: port 1 write addr 0x40, wdata 0x12345678, be 0xF -> mem_req with those values and gnt[1] same cycle, IDLE next cycle, no rvalid.
REQ-035 SHALL cover: rstn=0 one cycle during WAIT, mem_rvalid pulsed after reset -> no rvalid, next request granted port 0.
REQ-036 SHALL cover: MEM_ARB_PERF_CNT_EN defined, 5 grants port 0 and 3 port 1 -> perf_gnt_cnt = {32'd3, 32'd5}; undefined -> all zero.
